// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector engine.
// Holds the FSM encoding, mode constants and the saturating adder.
package mvm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mvm_state_e;

    localparam int MVM_INT = 0;
    localparam int MVM_BIN = 1;

    // Wide enough that a + b never wraps before clamping.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/mvm_dot_row.sv
// Combinational dot product of one latched input vector and one weight row.
// Integer mode builds a signed MAC sum; binary mode uses XNOR-popcount.
module mvm_dot_row
    import mvm_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int X_W   = 4,
    parameter int W_W   = 4,
    parameter int MODE  = MVM_INT,
    parameter int DOT_W = X_W + W_W + $clog2(N_IN)
) (
    input  logic [N_IN*X_W-1:0]     i_x,
    input  logic [N_IN*W_W-1:0]     i_w,
    output logic signed [DOT_W-1:0] o_dot
);

    generate
        if (MODE == MVM_BIN) begin : g_bin
            localparam int PC_W = $clog2(N_IN + 1);

            logic [N_IN-1:0] agree;
            logic [PC_W-1:0] pc;

            assign agree = ~(i_x[N_IN-1:0] ^ i_w[N_IN-1:0]);

            always_comb begin
                pc = '0;
                for (int k = 0; k < N_IN; k++) begin
                    pc = pc + PC_W'(agree[k]);
                end
            end

            // Each agreeing bit is +1, each disagreeing bit is -1.
            assign o_dot = DOT_W'(signed'({1'b0, pc}) * 2 - N_IN);
        end else begin : g_int
            always_comb begin
                o_dot = '0;
                for (int k = 0; k < N_IN; k++) begin
                    o_dot = o_dot
                          + DOT_W'($signed(i_x[k*X_W +: X_W]))
                          * DOT_W'($signed(i_w[k*W_W +: W_W]));
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mvm_stream.sv
// Streaming matrix-vector multiply: latches x on start, consumes N_OUT
// weight rows over valid/ready and keeps saturated, optionally accumulated results.
module mvm_stream
    import mvm_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int X_W   = 4,
    parameter int W_W   = 4,
    parameter int OUT_W = 16,
    parameter int MODE  = MVM_INT
) (
    input  logic                   i_clk_mvm,
    input  logic                   i_rst_mvm,
    input  logic                   i_start_mvm,
    input  logic                   i_acc_mvm,
    input  logic [N_IN*X_W-1:0]    i_x_bn,
    input  logic                   i_w_valid,
    input  logic [N_IN*W_W-1:0]    i_w_mvm,
    output logic                   o_w_ready,
    output logic                   o_ismvm,
    output logic                   o_done,
    output logic [N_OUT*OUT_W-1:0] o_wx_result
);

    localparam int DOT_W = X_W + W_W + $clog2(N_IN);
    localparam int ROW_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_OUT - 1);

    mvm_state_e state_q;
    mvm_state_e state_d;

    logic [ROW_W-1:0]    row_q;
    logic [ROW_W-1:0]    row_d;
    logic [N_IN*X_W-1:0] x_q;
    logic [N_IN*X_W-1:0] x_d;
    logic                acc_q;
    logic                acc_d;

    logic signed [OUT_W-1:0] res_q [N_OUT];
    logic signed [OUT_W-1:0] res_d [N_OUT];

    logic signed [DOT_W-1:0] dot;
    logic signed [SAT_W-1:0] sum_full;
    logic                    begin_pass;
    logic                    accept;

    assign begin_pass = (state_q == IDLE) && i_start_mvm;
    assign accept     = (state_q == RUN) && i_w_valid;

    mvm_dot_row #(
        .N_IN  (N_IN),
        .X_W   (X_W),
        .W_W   (W_W),
        .MODE  (MODE),
        .DOT_W (DOT_W)
    ) u_dot (
        .i_x   (x_q),
        .i_w   (i_w_mvm),
        .o_dot (dot)
    );

    // Both operands are sign-extended well past OUT_W so the clamp sees the true sum.
    assign sum_full = sat_add(
        acc_q ? SAT_W'(res_q[row_q]) : {SAT_W{1'b0}},
        SAT_W'(dot),
        OUT_W
    );

    always_ff @(posedge i_clk_mvm or negedge i_rst_mvm) begin
        if (!i_rst_mvm) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_start_mvm) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && (row_q == LAST_ROW)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_w_ready = 1'b0;
        o_ismvm   = 1'b0;
        o_done    = 1'b0;
        unique case (state_q)
            RUN: begin
                o_w_ready = 1'b1;
                o_ismvm   = 1'b1;
            end
            DONE: begin
                o_ismvm = 1'b1;
                o_done  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        x_d   = x_q;
        acc_d = acc_q;
        row_d = row_q;
        res_d = res_q;
        if (begin_pass) begin
            x_d   = i_x_bn;
            acc_d = i_acc_mvm;
            row_d = '0;
            if (!i_acc_mvm) begin
                for (int r = 0; r < N_OUT; r++) begin
                    res_d[r] = '0;
                end
            end
        end
        if (accept) begin
            res_d[row_q] = sum_full[OUT_W-1:0];
            row_d        = row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge i_clk_mvm or negedge i_rst_mvm) begin
        if (!i_rst_mvm) begin
            row_q <= '0;
            x_q   <= '0;
            acc_q <= 1'b0;
            for (int r = 0; r < N_OUT; r++) begin
                res_q[r] <= '0;
            end
        end else begin
            row_q <= row_d;
            x_q   <= x_d;
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    for (genvar r = 0; r < N_OUT; r++) begin : g_out
        assign o_wx_result[r*OUT_W +: OUT_W] = res_q[r];
    end

endmodule

// File: tb/tb_mvm_stream.sv
// Bench for mvm_stream: default, 8-bit saturating and binary instances
// checked against fixed vectors and an arithmetic reference model.
module tb_mvm_stream;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        acc;
    logic [15:0] x_bn;
    logic        valid;
    logic [15:0] w;

    logic        a_ready, a_ism, a_done;
    logic [63:0] a_res;
    logic        b_ready, b_ism, b_done;
    logic [31:0] b_res;

    logic        c_start, c_acc, c_valid;
    logic [7:0]  c_x, c_w;
    logic        c_ready, c_ism, c_done;
    logic [63:0] c_res;

    int n_pass;
    int n_total;

    int m16 [4];
    int m8  [4];
    int mc  [4];

    typedef struct packed {
        logic [15:0] x;
        logic [63:0] rows;
        logic        acc;
        logic [1:0]  gap;
        logic        retrig;
        logic [63:0] e16;
        logic [31:0] e8;
    } vec_t;

    vec_t tbl [7];

    mvm_stream u_a (
        .i_clk_mvm   (clk),
        .i_rst_mvm   (rst_n),
        .i_start_mvm (start),
        .i_acc_mvm   (acc),
        .i_x_bn      (x_bn),
        .i_w_valid   (valid),
        .i_w_mvm     (w),
        .o_w_ready   (a_ready),
        .o_ismvm     (a_ism),
        .o_done      (a_done),
        .o_wx_result (a_res)
    );

    mvm_stream #(.OUT_W(8)) u_b (
        .i_clk_mvm   (clk),
        .i_rst_mvm   (rst_n),
        .i_start_mvm (start),
        .i_acc_mvm   (acc),
        .i_x_bn      (x_bn),
        .i_w_valid   (valid),
        .i_w_mvm     (w),
        .o_w_ready   (b_ready),
        .o_ismvm     (b_ism),
        .o_done      (b_done),
        .o_wx_result (b_res)
    );

    mvm_stream #(.N_IN(8), .X_W(1), .W_W(1), .MODE(1)) u_c (
        .i_clk_mvm   (clk),
        .i_rst_mvm   (rst_n),
        .i_start_mvm (c_start),
        .i_acc_mvm   (c_acc),
        .i_x_bn      (c_x),
        .i_w_valid   (c_valid),
        .i_w_mvm     (c_w),
        .o_w_ready   (c_ready),
        .o_ismvm     (c_ism),
        .o_done      (c_done),
        .o_wx_result (c_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int wd);
        int hi;
        int lo;
        hi = (1 << (wd - 1)) - 1;
        lo = -(1 << (wd - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int dot_int(input logic [15:0] xv, input logic [15:0] wv);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s += int'($signed(xv[k*4 +: 4])) * int'($signed(wv[k*4 +: 4]));
        end
        return s;
    endfunction

    function automatic int dot_bin(input logic [7:0] xv, input logic [7:0] wv);
        int m;
        m = 0;
        for (int k = 0; k < 8; k++) begin
            if (xv[k] == wv[k]) m++;
        end
        return 2 * m - 8;
    endfunction

    function automatic int a_el(input int r);
        return int'($signed(a_res[r*16 +: 16]));
    endfunction

    function automatic int b_el(input int r);
        return int'($signed(b_res[r*8 +: 8]));
    endfunction

    function automatic int c_el(input int r);
        return int'($signed(c_res[r*16 +: 16]));
    endfunction

    task automatic run_pass(
        input logic [15:0] xv,
        input logic [63:0] rows,
        input logic        av,
        input int          gap,
        input bit          retrig
    );
        int  row;
        int  cyc;
        int  d;
        bit  v;
        bit  ok_ready;
        bit  early;
        bit  pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1;
        acc   = av;
        x_bn  = xv;
        valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        x_bn  = 16'($urandom);
        for (int r = 0; r < 4; r++) begin
            d = dot_int(xv, rows[r*16 +: 16]);
            m16[r] = sat((av ? m16[r] : 0) + d, 16);
            m8[r]  = sat((av ? m8[r] : 0) + d, 8);
        end
        row      = 0;
        cyc      = 0;
        ok_ready = 1'b1;
        early    = 1'b0;
        while (row < 4 && cyc < 64) begin
            if (!a_ready || !b_ready) ok_ready = 1'b0;
            if (a_done || b_done) early = 1'b1;
            if (gap == 0) v = 1'b1;
            else if (gap == 1) v = pat[cyc % 7];
            else v = (cyc > 30) ? 1'b1 : 1'($urandom_range(0, 1));
            valid = v;
            w     = rows[row*16 +: 16];
            start = retrig && (cyc == 1);
            if (retrig) x_bn = 16'($urandom);
            @(negedge clk);
            if (v) row++;
            cyc++;
        end
        valid = 1'b0;
        start = 1'b0;
        chk("ready_held", longint'(ok_ready), 1);
        chk("no_early_done", longint'(early), 0);
        chk("rows_accepted", row, 4);
        chk("done_pulse_a", longint'(a_done), 1);
        chk("done_pulse_b", longint'(b_done), 1);
        if (gap == 0) chk("latency", cyc, 4);
        start = retrig;
        x_bn  = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", longint'(a_done), 0);
        chk("idle_after", longint'(a_ism), 0);
    endtask

    task automatic c_pass(input logic [7:0] xv, input logic [31:0] rows, input logic av);
        int row;
        int cyc;
        @(negedge clk);
        c_start = 1'b1;
        c_acc   = av;
        c_x     = xv;
        @(negedge clk);
        c_start = 1'b0;
        c_x     = ~xv;
        for (int r = 0; r < 4; r++) begin
            mc[r] = sat((av ? mc[r] : 0) + dot_bin(xv, rows[r*8 +: 8]), 16);
        end
        row = 0;
        cyc = 0;
        while (row < 4 && cyc < 16) begin
            c_valid = 1'b1;
            c_w     = rows[row*8 +: 8];
            @(negedge clk);
            row++;
            cyc++;
        end
        c_valid = 1'b0;
        chk("bin_done", longint'(c_done), 1);
        @(negedge clk);
        chk("bin_idle", longint'(c_ism), 0);
    endtask

    initial begin
        int bexp [4];
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        acc     = 1'b0;
        x_bn    = '0;
        valid   = 1'b0;
        w       = '0;
        c_start = 1'b0;
        c_acc   = 1'b0;
        c_x     = '0;
        c_valid = 1'b0;
        c_w     = '0;
        for (int r = 0; r < 4; r++) begin
            m16[r] = 0;
            m8[r]  = 0;
            mc[r]  = 0;
        end

        tbl[0] = '{16'h7777, 64'h8888_8888_8888_8888, 1'b0, 2'd0, 1'b0,
                   64'hFF20_FF20_FF20_FF20, 32'h8080_8080};
        tbl[1] = '{16'h7777, 64'h8888_8888_8888_8888, 1'b1, 2'd0, 1'b1,
                   64'hFE40_FE40_FE40_FE40, 32'h8080_8080};
        tbl[2] = '{16'h7777, 64'h8888_8888_8888_8888, 1'b0, 2'd1, 1'b0,
                   64'hFF20_FF20_FF20_FF20, 32'h8080_8080};
        tbl[3] = '{16'h1111, 64'h1234_0000_FFFF_7777, 1'b0, 2'd1, 1'b0,
                   64'h000A_0000_FFFC_001C, 32'h0A00_FC1C};
        tbl[4] = '{16'h1111, 64'h1234_0000_FFFF_7777, 1'b1, 2'd0, 1'b0,
                   64'h0014_0000_FFF8_0038, 32'h1400_F838};
        tbl[5] = '{16'h8888, 64'h8888_0000_7777_8888, 1'b0, 2'd1, 1'b0,
                   64'h0100_0000_FF20_0100, 32'h7F00_807F};
        tbl[6] = '{16'h8888, 64'h8888_0000_7777_8888, 1'b1, 2'd0, 1'b0,
                   64'h0200_0000_FE40_0200, 32'h7F00_807F};

        #12;
        chk("rst_ready", longint'(a_ready), 0);
        chk("rst_busy", longint'(a_ism), 0);
        chk("rst_done", longint'(a_done), 0);
        chk("rst_res_a", longint'(a_res), 0);
        chk("rst_res_c", longint'(c_res), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_pass(tbl[i].x, tbl[i].rows, tbl[i].acc, int'(tbl[i].gap), tbl[i].retrig);
            for (int r = 0; r < 4; r++) begin
                chk($sformatf("tbl%0d_a%0d", i, r), a_el(r),
                    int'($signed(tbl[i].e16[r*16 +: 16])));
                chk($sformatf("tbl%0d_b%0d", i, r), b_el(r),
                    int'($signed(tbl[i].e8[r*8 +: 8])));
            end
        end

        for (int i = 0; i < 16; i++) begin
            run_pass(16'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 2, 1'b0);
            for (int r = 0; r < 4; r++) begin
                chk($sformatf("rnd%0d_a%0d", i, r), a_el(r), m16[r]);
                chk($sformatf("rnd%0d_b%0d", i, r), b_el(r), m8[r]);
            end
        end

        // Reset lands after two accepted rows of a fresh pass.
        @(negedge clk);
        start = 1'b1;
        acc   = 1'b0;
        x_bn  = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        w     = 16'h8888;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_row1", a_el(1), -224);
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("mid_rst_busy", longint'(a_ism), 0);
        chk("mid_rst_ready", longint'(a_ready), 0);
        chk("mid_rst_res_a", longint'(a_res), 0);
        chk("mid_rst_res_b", longint'(b_res), 0);
        for (int r = 0; r < 4; r++) begin
            m16[r] = 0;
            m8[r]  = 0;
            mc[r]  = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(16'h7777, 64'h8888_8888_8888_8888, 1'b1, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("post_rst_a%0d", r), a_el(r), -224);
            chk($sformatf("post_rst_b%0d", r), b_el(r), -128);
        end

        bexp = '{8, -8, 0, 0};
        c_pass(8'hF0, 32'hAA_FF_0F_F0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("bin_fix%0d", r), c_el(r), bexp[r]);
        end
        for (int i = 0; i < 6; i++) begin
            c_pass(8'($urandom), $urandom, 1'($urandom_range(0, 1)));
            for (int r = 0; r < 4; r++) begin
                chk($sformatf("bin_rnd%0d_%0d", i, r), c_el(r), mc[r]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
